// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter between the in-order WB stage and a multicycle unit,
// with per-register busy tracking for decode hazards and a starvation guard.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        mc_issue,
    input  logic [4:0]  mc_issue_addr,
    input  logic        mc_valid,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic [4:0]  addr1,
    input  logic [4:0]  addr2,
    input  logic [4:0]  dec_rd,
    output logic        hazard,
    output logic        rf_reg_write,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_rd
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        real_wb, prio_mc;
    logic        grant_mc, grant_wb;
    logic        ready_c, stall_c, wr_c;
    logic [4:0]  wr_addr_c;
    logic [31:0] wr_data_c;
    logic        mc_xfer;
    logic        haz_c;

    assign real_wb = wb_valid && (wb_addr != 5'd0);
    assign prio_mc = (cnt_q == LIMIT);

    // MC handshake: a result moves on any cycle where mc_valid && mc_ready;
    // the MC unit holds addr/data stable until then. WB holds while wb_stall.
    always_comb begin
        grant_mc = 1'b0;
        grant_wb = 1'b0;
        ready_c  = 1'b0;
        stall_c  = 1'b0;
        if (prio_mc && mc_valid) begin
            grant_mc = 1'b1;
            ready_c  = 1'b1;
            stall_c  = wb_valid;
        end else if (real_wb) begin
            grant_wb = 1'b1;
        end else begin
            ready_c  = 1'b1;
            grant_mc = mc_valid;
        end
    end

    always_comb begin
        wr_c      = 1'b0;
        wr_addr_c = 5'd0;
        wr_data_c = 32'd0;
        if (grant_mc && (mc_addr != 5'd0)) begin
            wr_c      = 1'b1;
            wr_addr_c = mc_addr;
            wr_data_c = mc_data;
        end else if (grant_wb) begin
            wr_c      = 1'b1;
            wr_addr_c = wb_addr;
            wr_data_c = wb_data;
        end
    end

    assign mc_xfer = mc_valid && ready_c;

    always_comb begin
        cnt_d = 'd0;
        if (mc_valid && !ready_c) begin
            cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    // Set is applied after clear so a same-cycle issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (mc_xfer) begin
            busy_d[mc_addr] = 1'b0;
        end
        if (mc_issue) begin
            busy_d[mc_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 32'd0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign haz_c = ((addr1  != 5'd0) && busy_q[addr1])
                 | ((addr2  != 5'd0) && busy_q[addr2])
                 | ((dec_rd != 5'd0) && busy_q[dec_rd]);

    // All outputs are held low for as long as reset is asserted.
    assign rf_reg_write = rst_n & wr_c;
    assign rf_rd_addr   = rst_n ? wr_addr_c : 5'd0;
    assign rf_rd        = rst_n ? wr_data_c : 32'd0;
    assign mc_ready     = rst_n & ready_c;
    assign wb_stall     = rst_n & stall_c;
    assign hazard       = rst_n & haz_c;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: write-port grant, starvation guard,
// busy tracking and asynchronous reset behaviour.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mc_issue;
    logic [4:0]  mc_issue_addr;
    logic        mc_valid;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [4:0]  addr1, addr2, dec_rd;
    logic        hazard;
    logic        rf_reg_write;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd;

    int total = 0;
    int bad   = 0;

    logic [31:0] rf_model [32];

    regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
        .mc_issue(mc_issue), .mc_issue_addr(mc_issue_addr),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready),
        .addr1(addr1), .addr2(addr2), .dec_rd(dec_rd), .hazard(hazard),
        .rf_reg_write(rf_reg_write), .rf_rd_addr(rf_rd_addr), .rf_rd(rf_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the register file's write port.
    always @(posedge clk) begin
        if (rf_reg_write) rf_model[rf_rd_addr] <= rf_rd;
    end

    task automatic idle();
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        mc_issue = 0; mc_issue_addr = 0;
        mc_valid = 0; mc_addr = 0; mc_data = 0;
        addr1 = 0; addr2 = 0; dec_rd = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        wb_valid = 1; wb_addr = 5'd5; wb_data = 32'd21; mc_valid = 1; mc_addr = 5'd6;
        @(negedge clk); #2;
        total++; if (rf_reg_write !== 1'b0) begin bad++; $display("FAIL reset_wr got=%0b exp=0", rf_reg_write); end
        total++; if (rf_rd_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", rf_rd_addr); end
        total++; if (rf_rd !== 32'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", rf_rd); end
        total++; if (mc_ready !== 1'b0) begin bad++; $display("FAIL reset_mc_ready got=%0b exp=0", mc_ready); end
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%0b exp=0", hazard); end
        @(negedge clk);
        idle();
        rst_n = 1;
    endtask

    task automatic test_wb_write();
        @(negedge clk);
        wb_valid = 1; wb_addr = 5'd5; wb_data = 32'd21;
        #2;
        total++; if (rf_reg_write !== 1'b1) begin bad++; $display("FAIL wb_wr got=%0b exp=1", rf_reg_write); end
        total++; if (rf_rd_addr !== 5'd5) begin bad++; $display("FAIL wb_addr got=%0d exp=5", rf_rd_addr); end
        total++; if (rf_rd !== 32'd21) begin bad++; $display("FAIL wb_data got=%0d exp=21", rf_rd); end
        total++; if (wb_stall !== 1'b0) begin bad++; $display("FAIL wb_stall got=%0b exp=0", wb_stall); end
        @(negedge clk);
        idle();
        #2;
        total++; if (rf_model[5] !== 32'd21) begin bad++; $display("FAIL wb_readback got=%0d exp=21", rf_model[5]); end
        total++; if (rf_reg_write !== 1'b0) begin bad++; $display("FAIL idle_wr got=%0b exp=0", rf_reg_write); end
    endtask

    task automatic test_mc_hazard();
        @(negedge clk);
        mc_issue = 1; mc_issue_addr = 5'd7; addr1 = 5'd7;
        #2;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL haz_issue_cycle got=%0b exp=0", hazard); end
        @(negedge clk);
        mc_issue = 0;
        #2;
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL haz_after_issue got=%0b exp=1", hazard); end
        @(negedge clk);
        mc_valid = 1; mc_addr = 5'd7; mc_data = 32'hDEAD;
        #2;
        total++; if (mc_ready !== 1'b1) begin bad++; $display("FAIL mc_ready got=%0b exp=1", mc_ready); end
        total++; if (rf_reg_write !== 1'b1 || rf_rd_addr !== 5'd7 || rf_rd !== 32'hDEAD) begin
            bad++; $display("FAIL mc_write got=%0b/%0d/%0h exp=1/7/dead", rf_reg_write, rf_rd_addr, rf_rd); end
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL haz_xfer_cycle got=%0b exp=1", hazard); end
        @(negedge clk);
        mc_valid = 0;
        #2;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL haz_cleared got=%0b exp=0", hazard); end
        total++; if (rf_model[7] !== 32'hDEAD) begin bad++; $display("FAIL mc_readback got=%0h exp=dead", rf_model[7]); end
        idle();
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wb_valid = 1; wb_addr = 5'(10 + i); wb_data = 32'(100 + i);
            mc_valid = 1; mc_addr = 5'd12; mc_data = 32'hC0DE;
            #2;
            total++; if (mc_ready !== 1'b0) begin bad++; $display("FAIL starve_deny%0d got=%0b exp=0", i, mc_ready); end
            total++; if (wb_stall !== 1'b0 || rf_rd_addr !== 5'(10 + i)) begin
                bad++; $display("FAIL starve_wb%0d got=%0b/%0d exp=0/%0d", i, wb_stall, rf_rd_addr, 10 + i); end
        end
        @(negedge clk);
        #2;
        total++; if (mc_ready !== 1'b1) begin bad++; $display("FAIL starve_grant got=%0b exp=1", mc_ready); end
        total++; if (wb_stall !== 1'b1) begin bad++; $display("FAIL starve_stall got=%0b exp=1", wb_stall); end
        total++; if (rf_rd_addr !== 5'd12 || rf_rd !== 32'hC0DE) begin
            bad++; $display("FAIL starve_mc_wr got=%0d/%0h exp=12/c0de", rf_rd_addr, rf_rd); end
        @(negedge clk);
        mc_valid = 0;
        #2;
        total++; if (wb_stall !== 1'b0 || rf_reg_write !== 1'b1 || rf_rd_addr !== 5'd13) begin
            bad++; $display("FAIL starve_wb_resume got=%0b/%0b/%0d exp=0/1/13", wb_stall, rf_reg_write, rf_rd_addr); end
        @(negedge clk);
        idle();
        #2;
        total++; if (rf_model[12] !== 32'hC0DE) begin bad++; $display("FAIL starve_readback got=%0h exp=c0de", rf_model[12]); end
    endtask

    task automatic test_wb_x0();
        @(negedge clk);
        wb_valid = 1; wb_addr = 5'd0; wb_data = 32'h1234;
        mc_valid = 1; mc_addr = 5'd4; mc_data = 32'h44;
        #2;
        total++; if (mc_ready !== 1'b1 || wb_stall !== 1'b0) begin
            bad++; $display("FAIL x0_grant got=%0b/%0b exp=1/0", mc_ready, wb_stall); end
        total++; if (rf_rd_addr !== 5'd4 || rf_rd !== 32'h44) begin
            bad++; $display("FAIL x0_write got=%0d/%0h exp=4/44", rf_rd_addr, rf_rd); end
        @(negedge clk);
        wb_valid = 0; mc_addr = 5'd0; mc_data = 32'h99;
        #2;
        total++; if (mc_ready !== 1'b1 || rf_reg_write !== 1'b0) begin
            bad++; $display("FAIL mc_x0 got=%0b/%0b exp=1/0", mc_ready, rf_reg_write); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_busy_rules();
        @(negedge clk);
        mc_issue = 1; mc_issue_addr = 5'd9;
        @(negedge clk);
        mc_issue = 1; mc_issue_addr = 5'd9; mc_valid = 1; mc_addr = 5'd9; mc_data = 32'h9;
        @(negedge clk);
        idle(); addr1 = 5'd9;
        #2;
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL set_wins got=%0b exp=1", hazard); end
        mc_valid = 1; mc_addr = 5'd9;
        @(negedge clk);
        mc_valid = 0;
        #2;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL busy9_clear got=%0b exp=0", hazard); end
        idle();
        mc_issue = 1; mc_issue_addr = 5'd0;
        @(negedge clk);
        mc_issue = 0;
        #2;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL x0_never_busy got=%0b exp=0", hazard); end
        mc_issue = 1; mc_issue_addr = 5'd3;
        @(negedge clk);
        mc_issue = 0; addr2 = 5'd3;
        #2;
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL haz_addr2 got=%0b exp=1", hazard); end
        addr2 = 0; dec_rd = 5'd3;
        #1;
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL haz_dec_rd got=%0b exp=1", hazard); end
        dec_rd = 5'd2;
        #1;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL haz_other_reg got=%0b exp=0", hazard); end
        idle();
    endtask

    task automatic test_reset_mid();
        // busy[3] is still set from the previous scenario; build starve_cnt = 2.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wb_valid = 1; wb_addr = 5'd20; wb_data = 32'd20;
            mc_valid = 1; mc_addr = 5'd21; mc_data = 32'd21;
        end
        @(negedge clk);
        wb_valid = 0; addr1 = 5'd3;
        #2;
        total++; if (hazard !== 1'b1 || mc_ready !== 1'b1) begin
            bad++; $display("FAIL pre_reset got=%0b/%0b exp=1/1", hazard, mc_ready); end
        rst_n = 0;
        #1;
        total++; if (hazard !== 1'b0 || mc_ready !== 1'b0 || rf_reg_write !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%0b/%0b/%0b exp=0/0/0", hazard, mc_ready, rf_reg_write); end
        @(negedge clk);
        rst_n = 1; mc_valid = 0;
        @(negedge clk);
        #2;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL post_reset_haz got=%0b exp=0", hazard); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wb_valid = 1; wb_addr = 5'd20; wb_data = 32'd20;
            mc_valid = 1; mc_addr = 5'd21; mc_data = 32'd21;
            #2;
            total++; if (mc_ready !== 1'b0) begin bad++; $display("FAIL post_reset_cnt%0d got=%0b exp=0", i, mc_ready); end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_wb_write();
        test_mc_hazard();
        test_starvation();
        test_wb_x0();
        test_busy_rules();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage (WB) and a multicycle execution unit (MC, e.g. mul/div). It tracks destination registers with outstanding MC results and flags decode-stage hazards against them. A starvation counter guarantees MC forward progress by holding WB for one cycle. It sits between the WB stage, the MC unit and `regfile`, and drives `regfile`'s `reg_write`/`rd_addr`/`rd` inputs.

## Interface
- `STARVE_LIMIT`, 4: consecutive denied MC cycles before MC gets priority (legal 1..7).
- `CNT_W`, 3: starvation counter width; must satisfy `2^CNT_W > STARVE_LIMIT`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wb_valid` in 1: WB stage requests a write.
- `wb_addr` in 5: WB destination register.
- `wb_data` in 32: WB write data.
- `wb_stall` out 1: WB request not granted this cycle; pipeline holds WB.
- `mc_issue` in 1: MC op dispatched this cycle.
- `mc_issue_addr` in 5: dispatched op's destination register.
- `mc_valid` in 1: MC result ready to write.
- `mc_addr` in 5: MC result destination register.
- `mc_data` in 32: MC result data.
- `mc_ready` out 1: MC result accepted; transfer when `mc_valid && mc_ready`.
- `addr1`, `addr2`, `dec_rd` in 5 each: decode-stage sources and destination.
- `hazard` out 1: decode must stall.
- `rf_reg_write` out 1, `rf_rd_addr` out 5, `rf_rd` out 32: to `regfile` `reg_write`, `rd_addr`, `rd`.

## Operation
- State:
  - `busy[31:1]`: one bit per register; x0 is never busy.
  - `starve_cnt[CNT_W-1:0]`.
- A WB request is *real* when `wb_valid && wb_addr != 0`. A WB request to x0 is consumed with no write and no stall.
- `prio_mc = (starve_cnt == STARVE_LIMIT)`.
- Grant, combinational, evaluated each cycle:
  - `prio_mc && mc_valid`: grant MC; `wb_stall = wb_valid`.
  - Else, real WB: grant WB; `mc_ready = 0`; `wb_stall = 0`.
  - Else: `mc_ready = 1`, and MC is granted if `mc_valid`.
- Write port:
  - `rf_reg_write = 1` only for a granted write with a nonzero address.
  - `rf_rd_addr` and `rf_rd` come from the granted source; they are 0 when no write is granted.
  - An MC result to x0 is accepted (`mc_ready = 1`) and no write is performed.
- Starvation counter, updated at the clock edge:
  - Increment, saturating at `STARVE_LIMIT`, when `mc_valid && !mc_ready`.
  - Clear to 0 on an MC transfer or when `mc_valid = 0`.
- Busy bits, updated at the clock edge:
  - Set `busy[mc_issue_addr]` on `mc_issue` with a nonzero address.
  - Clear `busy[mc_addr]` on an MC transfer.
  - If a set and a clear hit the same address in the same cycle, the set wins.
- `hazard = busy[addr1] | busy[addr2] | busy[dec_rd]`, each term masked when its address is 0. It is combinational from the registered `busy`.
- The MC unit keeps `mc_valid`, `mc_addr` and `mc_data` stable until the transfer. The pipeline keeps WB signals stable while `wb_stall = 1`.

## Timing
- Reset (`rst_n = 0`, asynchronous):
  - `busy = 0` and `starve_cnt = 0` immediately.
  - While reset is asserted, all outputs are forced to 0: `rf_reg_write`, `rf_rd_addr`, `rf_rd`, `mc_ready`, `wb_stall`, `hazard`.
  - A reset mid-operation drops all busy bits; any in-flight MC result is the MC unit's responsibility to flush.
- Write-port latency is 0. The grant is combinational, and `regfile` captures the data at the same rising edge, so it is readable from the next cycle.
- Busy set/clear takes effect from the cycle after the `mc_issue` or transfer edge. An instruction in decode during the issue cycle is not flagged. The issue logic never dispatches a dependent instruction in that same cycle.
- Worst-case MC wait under continuous real WB traffic is `STARVE_LIMIT` denied cycles; MC is granted on the next cycle. That forced MC grant costs WB exactly one stall cycle, after which `starve_cnt = 0` and WB has priority again.
- Counter saturation: the count never exceeds `STARVE_LIMIT`, even if `mc_valid` remains high and MC keeps being denied.

## Test plan
- Reset, then `wb_valid = 1`, `wb_addr = 5`, `wb_data = 21` → `rf_reg_write = 1`, `rf_rd_addr = 5`, `rf_rd = 21`, `wb_stall = 0`; register 5 reads 21 the next cycle.
- `mc_issue` with `mc_issue_addr = 7`, then `addr1 = 7` → `hazard = 1` from the next cycle. `mc_valid` with `mc_addr = 7`, `mc_data = 0xDEAD` and no WB → `mc_ready = 1`, write performed, `hazard = 0` the cycle after.
- Real WB every cycle with `mc_valid` held and `STARVE_LIMIT = 4` → `mc_ready = 0` for 4 cycles, then `mc_ready = 1` and `wb_stall = 1` for one cycle, then `wb_stall = 0` and WB granted.
- `wb_valid = 1`, `wb_addr = 0` together with `mc_valid` → MC granted, `wb_stall = 0`, `rf_rd_addr` = `mc_addr`.
- Same-cycle `mc_issue` to x9 and MC transfer to x9 → `busy[9]` remains 1. Issue to x0 → `hazard` stays 0 for `addr1 = 0`.
- With `busy[3] = 1` and `starve_cnt = 2`, assert `rst_n = 0` between edges → `hazard` and `mc_ready` go to 0 immediately, and stay 0 after release until a new issue.
